// File: rtl/tx_byte_striper_pkg.sv
// Shared types and constants for the TX byte striper: sync-header codes,
// the lane-count encoding driven by the framer, and the lane-count helper.
package tx_stripe_pkg;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [1:0] SYNC_HDR_OS   = 2'b01;

  typedef enum logic [1:0] {
    X4  = 2'b00,
    X8  = 2'b01,
    X16 = 2'b10,
    X32 = 2'b11
  } lane_cfg_e;

  // Active lane count for an encoded lane configuration: 4, 8, 16 or 32.
  function automatic int lanes_from_gen(lane_cfg_e gen);
    return 4 << int'(gen);
  endfunction

endpackage

// File: rtl/tx_byte_striper_if.sv
// Framer-to-striper bus: framed word and flags in, striped lane symbols and
// block markers out. The master side is the upstream framer / test driver.
interface tx_byte_striper_if #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int MAX_LANES    = 32
);

  logic                              i_Valid;
  logic [SYMBOL_WIDTH*MAX_LANES-1:0] i_Framed_Data;
  logic                              i_Sync_Sel;
  logic                              i_Idle_Indicator;
  logic [1:0]                        i_GEN_Lanes;

  logic                              o_Ready;
  logic                              o_Valid;
  logic [SYMBOL_WIDTH*MAX_LANES-1:0] o_Lane_Data;
  logic [MAX_LANES-1:0]              o_Lane_Mask;
  logic                              o_Sync_Valid;
  logic [1:0]                        o_Sync_Header;
  logic                              o_Idle;
  logic                              o_Underflow;

  modport master (
    output i_Valid, i_Framed_Data, i_Sync_Sel, i_Idle_Indicator, i_GEN_Lanes,
    input  o_Ready, o_Valid, o_Lane_Data, o_Lane_Mask, o_Sync_Valid,
           o_Sync_Header, o_Idle, o_Underflow
  );

  modport slave (
    input  i_Valid, i_Framed_Data, i_Sync_Sel, i_Idle_Indicator, i_GEN_Lanes,
    output o_Ready, o_Valid, o_Lane_Data, o_Lane_Mask, o_Sync_Valid,
           o_Sync_Header, o_Idle, o_Underflow
  );

endinterface

// File: rtl/tx_byte_striper_slice_mux.sv
// Selects slice sc of a held word onto the lane slots: symbol sc*N+j lands
// in lane j for j < N, and lanes at or beyond N are forced to zero.
module stripe_slice_mux
  import tx_stripe_pkg::*;
#(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int MAX_LANES        = 2**SYMBOL_PTR_WIDTH
) (
  input  logic [SYMBOL_WIDTH*MAX_LANES-1:0] word,
  input  logic [SYMBOL_PTR_WIDTH-1:0]       sc,
  input  lane_cfg_e                         lanes,
  output logic [SYMBOL_WIDTH*MAX_LANES-1:0] lane_data
);

  logic [SYMBOL_WIDTH*MAX_LANES-1:0] shifted;
  int                                base;

  // Shift the wanted slice up to symbol 0 (MSBs), then keep only active lanes.
  always_comb begin
    base      = int'(sc) * lanes_from_gen(lanes);
    shifted   = word << (base * SYMBOL_WIDTH);
    lane_data = '0;
    for (int j = 0; j < MAX_LANES; j++) begin
      if (j < lanes_from_gen(lanes)) begin
        lane_data[(MAX_LANES-1-j)*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
          shifted[(MAX_LANES-1-j)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

endmodule

// File: rtl/tx_byte_striper.sv
// TX byte striper: holds one framed word, emits it as N-symbol slices (one
// per cycle) across the active lanes, and tracks 16-symbol block boundaries
// so each block start carries its sync header. Lane count changes are only
// taken between blocks with nothing held, so a block never mixes widths.
module tx_byte_striper
  import tx_stripe_pkg::*;
#(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int MAX_LANES        = 2**SYMBOL_PTR_WIDTH,
  parameter int BLOCK_SYMBOLS    = 16
) (
  input logic              CLK,
  input logic              RST,
  tx_byte_striper_if.slave bus
);

  localparam int WORD_W = SYMBOL_WIDTH * MAX_LANES;
  localparam int BC_W   = $clog2(BLOCK_SYMBOLS);
  localparam logic [MAX_LANES-1:0] X4_MASK = {{4{1'b1}}, {(MAX_LANES-4){1'b0}}};

  // hold stage
  lane_cfg_e                   lanes_p0;
  logic                        hold_full_p0;
  logic [WORD_W-1:0]           hold_data_p0;
  logic                        hold_idle_p0;
  logic [SYMBOL_PTR_WIDTH-1:0] sc_p0;
  logic [BC_W-1:0]             bc_p0;

  // registered outputs
  logic                        vld_p1;
  logic [WORD_W-1:0]           lane_data_p1;
  logic [MAX_LANES-1:0]        mask_p1;
  logic                        sync_vld_p1;
  logic [1:0]                  hdr_p1;
  logic                        idle_p1;
  logic                        uflow_p1;

  logic [SYMBOL_PTR_WIDTH-1:0] sc_last;
  logic                        emit;
  logic                        wrap;
  logic                        ready;
  logic                        take;
  logic                        block_start;
  logic                        underflow_now;
  logic [MAX_LANES-1:0]        lane_mask;
  logic [WORD_W-1:0]           slice_data;

  // Handshake and emission decisions for the current cycle.
  always_comb begin
    sc_last       = SYMBOL_PTR_WIDTH'((MAX_LANES >> (int'(lanes_p0) + 2)) - 1);
    emit          = hold_full_p0;
    wrap          = hold_full_p0 && (sc_p0 == sc_last);
    ready         = !hold_full_p0 || wrap;
    take          = bus.i_Valid && ready;
    block_start   = emit && (bc_p0 == '0);
    underflow_now = !hold_full_p0 && (bc_p0 != '0);
  end

  // Active-lane mask, lane 0 in the MSB.
  always_comb begin
    lane_mask = '0;
    for (int j = 0; j < MAX_LANES; j++) begin
      lane_mask[MAX_LANES-1-j] = (j < lanes_from_gen(lanes_p0));
    end
  end

  stripe_slice_mux #(
    .SYMBOL_WIDTH     (SYMBOL_WIDTH),
    .SYMBOL_PTR_WIDTH (SYMBOL_PTR_WIDTH),
    .MAX_LANES        (MAX_LANES)
  ) u_slice_mux (
    .word      (hold_data_p0),
    .sc        (sc_p0),
    .lanes     (lanes_p0),
    .lane_data (slice_data)
  );

  // Control state: hold occupancy, slice/block counters, lane config.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full_p0 <= 1'b0;
      sc_p0        <= '0;
      bc_p0        <= '0;
      lanes_p0     <= X4;
    end else begin
      if (take) begin
        hold_full_p0 <= 1'b1;
      end else if (wrap) begin
        hold_full_p0 <= 1'b0;
      end
      if (emit) begin
        sc_p0 <= wrap ? '0 : sc_p0 + 1'b1;
        bc_p0 <= bc_p0 + 1'b1;
      end
      if (!hold_full_p0 && (bc_p0 == '0)) begin
        lanes_p0 <= lane_cfg_e'(bus.i_GEN_Lanes);
      end
    end
  end

  // Word storage, captured whenever a word is accepted.
  always_ff @(posedge CLK) begin
    if (take) begin
      hold_data_p0 <= bus.i_Framed_Data;
      hold_idle_p0 <= bus.i_Idle_Indicator;
    end
  end

  // Output register; the header register doubles as the per-block type latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1       <= 1'b0;
      lane_data_p1 <= '0;
      mask_p1      <= X4_MASK;
      sync_vld_p1  <= 1'b0;
      hdr_p1       <= 2'b00;
      idle_p1      <= 1'b0;
      uflow_p1     <= 1'b0;
    end else begin
      vld_p1       <= emit;
      lane_data_p1 <= emit ? slice_data : '0;
      mask_p1      <= lane_mask;
      sync_vld_p1  <= block_start;
      idle_p1      <= emit && hold_idle_p0;
      uflow_p1     <= underflow_now;
      if (block_start) begin
        hdr_p1 <= bus.i_Sync_Sel ? SYNC_HDR_OS : SYNC_HDR_DATA;
      end
    end
  end

  assign bus.o_Ready       = ready;
  assign bus.o_Valid       = vld_p1;
  assign bus.o_Lane_Data   = lane_data_p1;
  assign bus.o_Lane_Mask   = mask_p1;
  assign bus.o_Sync_Valid  = sync_vld_p1;
  assign bus.o_Sync_Header = hdr_p1;
  assign bus.o_Idle        = idle_p1;
  assign bus.o_Underflow   = uflow_p1;

endmodule

// File: tb/tb_tx_byte_striper.sv
// Directed bench for tx_byte_striper. Words use the pattern byte k of word w
// = (32*w + k) mod 256, so emission e in an N-lane mode must carry bytes
// N*e .. N*e+N-1 on lanes 0..N-1.
module tb_tx_byte_striper;

  localparam int SW   = 8;
  localparam int MAXL = 32;
  localparam int WW   = SW * MAXL;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tx_byte_striper_if #(.SYMBOL_WIDTH(SW), .MAX_LANES(MAXL)) bus ();

  tx_byte_striper #(
    .SYMBOL_WIDTH     (SW),
    .SYMBOL_PTR_WIDTH (5),
    .MAX_LANES        (MAXL),
    .BLOCK_SYMBOLS    (16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] word_of(input int w);
    logic [WW-1:0] r;
    r = '0;
    for (int k = 0; k < MAXL; k++) r[WW-1-SW*k -: SW] = 8'((32*w + k) & 255);
    return r;
  endfunction

  function automatic logic [WW-1:0] exp_lanes(input int n, input int e);
    logic [WW-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[WW-1-SW*j -: SW] = 8'((n*e + j) & 255);
    return r;
  endfunction

  function automatic logic [MAXL-1:0] exp_mask(input int n);
    logic [MAXL-1:0] all;
    all = '1;
    return ~(all >> n);
  endfunction

  task automatic reset_checks(input string tag);
    check_val({tag, "_valid"}, bus.o_Valid, 0);
    check_val({tag, "_ready"}, bus.o_Ready, 1);
    check_val({tag, "_mask"},  bus.o_Lane_Mask, 32'hF000_0000);
    check_val({tag, "_lanes"}, bus.o_Lane_Data, 0);
    check_val({tag, "_sync"},  bus.o_Sync_Valid, 0);
    check_val({tag, "_hdr"},   bus.o_Sync_Header, 0);
    check_val({tag, "_idle"},  bus.o_Idle, 0);
    check_val({tag, "_uflow"}, bus.o_Underflow, 0);
  endtask

  // Offers nwords pattern words with the handshake and checks every emitted
  // slice. sel_e: emission index from which i_Sync_Sel is 1 (-1 never).
  // gap_w/gap_len: withhold word gap_w for gap_len ready cycles (-1 none).
  // gen2_e/gen2: drive i_GEN_Lanes=gen2 from emission gen2_e on (-1 never);
  // the expected lane count stays that of gen throughout.
  task automatic stream(input string tag, input int gen, input int nwords, input int sel_e,
                        input int gap_w, input int gap_len, input int gen2_e, input int gen2);
    int   n, s, total, wi, e, gap, cyc, uf, lim, late;
    logic rdy, took;
    n = 4 << gen; s = MAXL / n; total = nwords * s;
    wi = 0; e = 0; gap = 0; cyc = 0; uf = 0; lim = 0;
    while (e < total && lim < 400) begin
      bus.i_GEN_Lanes      = 2'((gen2_e >= 0 && e >= gen2_e) ? gen2 : gen);
      bus.i_Sync_Sel       = (sel_e >= 0 && e >= sel_e);
      bus.i_Framed_Data    = word_of(wi);
      bus.i_Idle_Indicator = (wi % 2) != 0;
      rdy = bus.o_Ready;
      if (wi == gap_w && gap < gap_len) begin
        bus.i_Valid = 1'b0;
        if (rdy) gap++;
      end else begin
        bus.i_Valid = (wi < nwords);
      end
      took = bus.i_Valid && rdy;
      tick();
      lim++;
      if (took && wi == 0) cyc = 0; else cyc++;
      if (took) wi++;
      if (bus.o_Underflow) uf++;
      if (bus.o_Valid) begin
        late = (gap_w >= 0 && e >= gap_w * s) ? gap_len : 0;
        check_val({tag, "_cycle"}, cyc, e + 1 + late);
        check_val({tag, "_lanes"}, bus.o_Lane_Data, exp_lanes(n, e));
        check_val({tag, "_mask"},  bus.o_Lane_Mask, exp_mask(n));
        check_val({tag, "_sync"},  bus.o_Sync_Valid, (e % 16) == 0);
        if ((e % 16) == 0)
          check_val({tag, "_hdr"}, bus.o_Sync_Header, (sel_e >= 0 && e >= sel_e) ? 2'b01 : 2'b10);
        check_val({tag, "_idle"},  bus.o_Idle, (e / s) % 2);
        e++;
      end
    end
    check_val({tag, "_slices"}, e, total);
    check_val({tag, "_uflow_count"}, uf, (gap_w >= 0) ? gap_len : 0);
    bus.i_Valid = 1'b0;
    tick();
    check_val({tag, "_idle_valid"}, bus.o_Valid, 0);
    check_val({tag, "_idle_uflow"}, bus.o_Underflow, 0);
  endtask

  initial begin
    int nrdy;
    rst                  = 1'b1;
    bus.i_Valid          = 1'b0;
    bus.i_Framed_Data    = '0;
    bus.i_Sync_Sel       = 1'b0;
    bus.i_Idle_Indicator = 1'b0;
    bus.i_GEN_Lanes      = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    reset_checks("reset");

    // x32 continuous flow, two full blocks
    stream("x32", 3, 32, -1, -1, 0, -1, 0);

    // x4 back-pressure, then reset in the middle of the word
    bus.i_GEN_Lanes   = 2'b00;
    bus.i_Framed_Data = word_of(0);
    bus.i_Valid       = 1'b1;
    tick();
    bus.i_Valid = 1'b0;
    nrdy = 0;
    for (int k = 0; k < 20 && !bus.o_Ready; k++) begin
      nrdy++;
      tick();
    end
    check_val("x4_ready_low_cycles", nrdy, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_checks("rst_mid");

    // x4 two words back to back; first slice must be a block start
    stream("x4", 0, 2, -1, -1, 0, -1, 0);

    // x8 data block, sync select raised at bc=5
    stream("x8sync", 1, 8, 5, -1, 0, -1, 0);

    // lane change 11 -> 01 mid-block, takes effect only at the next idle block start
    stream("chg32", 3, 16, -1, -1, 0, 5, 1);
    stream("chg8", 1, 4, -1, -1, 0, -1, 0);

    // starvation mid-block in x16 and in x32
    stream("uf16", 2, 8, -1, 4, 2, -1, 0);
    stream("uf32", 3, 16, -1, 7, 2, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
